mem_arbiter: RTL
================

// Module: mem_arbiter
// PURPOSE
//  Shares the single-port RAM (9-bit addr, 16-bit data) between the CPU and a secondary DMA/loader port.
//  The CPU cannot stall, so it has absolute priority and passes through combinationally.
//  The DMA port gets idle memory cycles through a req/ack handshake; an interrupted DMA read is retried.
//  Sits between cpu (mem_cmd/mem_addr/out) and the RAM instance at the top level.
// PARAMETERS
//  AW      9   RAM address width
//  DW      16  RAM data width
//  RD_LAT  1   RAM read latency in cycles, >=1: the address is held RD_LAT cycles, then ram_dout is valid
// PORTS
//  clk           in   1   rising-edge clock; sole clock
//  reset         in   1   synchronous, active-low reset (0 = reset)
//  cpu_mem_cmd   in   2   CPU command: 00 NOT, 01 READ, 10 WRITE; 11 is treated as NOT
//  cpu_mem_addr  in   AW  CPU address
//  cpu_wdata     in   DW  CPU write data
//  cpu_rdata     out  DW  read data to CPU (= ram_dout, combinational)
//  dma_req       in   1   DMA request; held with we/addr/wdata stable until dma_ack
//  dma_we        in   1   1 = write, 0 = read
//  dma_addr      in   AW  DMA address
//  dma_wdata     in   DW  DMA write data
//  dma_ack       out  1   1-cycle pulse: request accepted
//  dma_rvalid    out  1   1-cycle pulse: dma_rdata valid
//  dma_rdata     out  DW  registered DMA read data; holds until the next rvalid
//  dma_busy      out  1   1 while a DMA read is in flight
//  ram_addr      out  AW  RAM address
//  ram_write     out  1   RAM write enable
//  ram_din       out  DW  RAM write data
//  ram_dout      in   DW  RAM read data
// BEHAVIOUR
//  - Reset (reset==0 at posedge): state=IDLE, lat_cnt=0, dma_rdata=0, saved addr=0.
//    dma_ack, dma_rvalid, dma_busy = 0. Any in-flight read is dropped and no rvalid is issued.
//  - cpu_act = (cpu_mem_cmd==01 || cpu_mem_cmd==10).
//    When cpu_act=1: ram_addr=cpu_mem_addr, ram_write=(cmd==10), ram_din=cpu_wdata, regardless of state.
//  - States IDLE and RD. FSM outputs are Moore, except dma_ack and the DMA write enable, which are
//    combinational from IDLE & dma_req & !cpu_act.
//  - IDLE, dma_req=1, cpu_act=0, dma_we=1: in the same cycle ram_addr=dma_addr, ram_din=dma_wdata,
//    ram_write=1, dma_ack=1. Stay in IDLE. Back-to-back writes complete one per cycle.
//  - IDLE, dma_req=1, cpu_act=0, dma_we=0: dma_ack=1; latch dma_addr; lat_cnt<=RD_LAT; go to RD.
//  - IDLE with cpu_act=1: no ack; the request waits, with no limit.
//  - RD: dma_busy=1. When cpu_act=0: ram_addr=saved addr, ram_write=0, lat_cnt decrements.
//    When cpu_act=1: the CPU owns the RAM and lat_cnt reloads to RD_LAT (retry).
//  - RD, lat_cnt==1 and cpu_act=0 at the edge: dma_rdata<=ram_dout; next cycle dma_rvalid=1 and state=IDLE.
//    With no CPU interference, a read's rvalid comes RD_LAT+1 cycles after ack.
//  - In RD, a new dma_req is not acked until back in IDLE; ack can coincide with the rvalid cycle.
//  - Idle RAM (no owner): ram_write=0, ram_addr=0, ram_din=0.
//  - ram_write never asserts for the DMA while cpu_act=1, so a CPU write always wins.
// CONFIGURATION
//  MEM_ARB_STATS_EN defined: adds outputs stat_dma_ops[15:0] and stat_retries[15:0].
//    stat_dma_ops counts DMA acks; stat_retries counts lat_cnt reloads caused by CPU.
//    Both saturate at 16'hFFFF and are cleared by reset.
//  MEM_ARB_STATS_EN undefined: these ports and counters do not exist; all other behaviour is identical.
// STRUCTURE
//  Shared package mem_pkg: MNOT=2'b00, MREAD=2'b01, MWRITE=2'b10; typedef enum {ARB_IDLE, ARB_RD}.
//  Single module. No sub-module is required; capture registers reuse vDFFE.
// TESTING
//  1. Reset low 2 cycles, with dma_req=1 -> no ack, rvalid=0, busy=0, ram_write=0.
//  2. CPU idle, DMA write addr 9'h010 data 16'hBEEF -> ack and ram_write same cycle;
//     a later DMA read of 9'h010 gives rvalid at ack+2 (RD_LAT=1) with rdata=16'hBEEF.
//  3. CPU MWRITE 9'h020 in the same cycle as DMA write 9'h030 -> RAM sees only the CPU write;
//     DMA is acked on the first cycle with cpu cmd=00.
//  4. DMA read of 9'h005 while CPU issues MREAD for 2 cycles mid-latency -> counter reloads;
//     rvalid delayed 2 cycles; data correct; stat_retries=2 with MEM_ARB_STATS_EN.
//  5. Reset asserted while in RD -> no rvalid; IDLE next cycle; a new read is acked normally.
//  6. RD_LAT=3, 4 back-to-back DMA reads with CPU idle -> each rvalid exactly 4 cycles after its ack;
//     stat_dma_ops=4.

Source files
------------

// File: rtl/mem_pkg.sv
// rtl/mem_pkg.sv - shared command encodings and arbiter state type for the RAM arbiter
package mem_pkg;

    localparam logic [1:0] MNOT   = 2'b00;
    localparam logic [1:0] MREAD  = 2'b01;
    localparam logic [1:0] MWRITE = 2'b10;

    typedef enum logic {
        ARB_IDLE,
        ARB_RD
    } arb_state_t;

    // Command 11 is reserved and behaves as MNOT.
    function automatic logic is_cpu_act(input logic [1:0] cmd);
        return (cmd == MREAD) || (cmd == MWRITE);
    endfunction

endpackage

// File: rtl/vDFFE.sv
// rtl/vDFFE.sv - parameterised enabled D flip-flop bank with synchronous active-low clear
module vDFFE #(
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         resetn,
    input  logic         en,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    always_ff @(posedge clk) begin
        if (!resetn) begin
            q <= '0;
        end else if (en) begin
            q <= d;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - CPU-priority single-port RAM arbiter with DMA req/ack port and read retry
// Optional MEM_ARB_STATS_EN adds stat_dma_ops / stat_retries saturating counters.
module mem_arbiter
    import mem_pkg::*;
#(
    parameter int AW     = 9,
    parameter int DW     = 16,
    parameter int RD_LAT = 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [1:0]    cpu_mem_cmd,
    input  logic [AW-1:0] cpu_mem_addr,
    input  logic [DW-1:0] cpu_wdata,
    output logic [DW-1:0] cpu_rdata,
    input  logic          dma_req,
    input  logic          dma_we,
    input  logic [AW-1:0] dma_addr,
    input  logic [DW-1:0] dma_wdata,
    output logic          dma_ack,
    output logic          dma_rvalid,
    output logic [DW-1:0] dma_rdata,
    output logic          dma_busy,
    output logic [AW-1:0] ram_addr,
    output logic          ram_write,
    output logic [DW-1:0] ram_din,
    input  logic [DW-1:0] ram_dout
`ifdef MEM_ARB_STATS_EN
    ,
    output logic [15:0]   stat_dma_ops,
    output logic [15:0]   stat_retries
`endif
);

    localparam int LW = $clog2(RD_LAT + 1);

    arb_state_t    state;
    arb_state_t    state_nxt;
    logic [LW-1:0] lat_cnt;
    logic [AW-1:0] saved_addr;
    logic          cpu_act;
    logic          dma_go;
    logic          rd_take;
    logic          rd_done;

    assign cpu_act   = is_cpu_act(cpu_mem_cmd);
    // The reset gate keeps a held request from being acked while reset is low.
    assign dma_go    = reset && (state == ARB_IDLE) && dma_req && !cpu_act;
    assign rd_take   = dma_go && !dma_we;
    assign rd_done   = (state == ARB_RD) && !cpu_act && (lat_cnt == LW'(1));
    assign cpu_rdata = ram_dout;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= ARB_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ARB_IDLE: if (rd_take) state_nxt = ARB_RD;
            ARB_RD:   if (rd_done) state_nxt = ARB_IDLE;
            default:  state_nxt = ARB_IDLE;
        endcase
    end

    always_comb begin
        dma_ack   = dma_go;
        dma_busy  = (state == ARB_RD);
        ram_addr  = '0;
        ram_write = 1'b0;
        ram_din   = '0;
        if (cpu_act) begin
            ram_addr  = cpu_mem_addr;
            ram_write = (cpu_mem_cmd == MWRITE);
            ram_din   = cpu_wdata;
        end else if (dma_go && dma_we) begin
            ram_addr  = dma_addr;
            ram_write = 1'b1;
            ram_din   = dma_wdata;
        end else if (state == ARB_RD) begin
            ram_addr  = saved_addr;
        end
    end

    // Any CPU cycle during a read restarts the full latency window.
    always_ff @(posedge clk) begin
        if (!reset) begin
            lat_cnt    <= '0;
            dma_rvalid <= 1'b0;
        end else begin
            dma_rvalid <= rd_done;
            if (rd_take) begin
                lat_cnt <= LW'(RD_LAT);
            end else if (state == ARB_RD) begin
                lat_cnt <= cpu_act ? LW'(RD_LAT) : lat_cnt - LW'(1);
            end
        end
    end

    vDFFE #(.W(AW)) u_addr_reg (
        .clk    (clk),
        .resetn (reset),
        .en     (rd_take),
        .d      (dma_addr),
        .q      (saved_addr)
    );

    vDFFE #(.W(DW)) u_rdata_reg (
        .clk    (clk),
        .resetn (reset),
        .en     (rd_done),
        .d      (ram_dout),
        .q      (dma_rdata)
    );

`ifdef MEM_ARB_STATS_EN
    always_ff @(posedge clk) begin
        if (!reset) begin
            stat_dma_ops <= '0;
            stat_retries <= '0;
        end else begin
            if (dma_ack && (stat_dma_ops != 16'hFFFF)) begin
                stat_dma_ops <= stat_dma_ops + 16'd1;
            end
            if ((state == ARB_RD) && cpu_act && (stat_retries != 16'hFFFF)) begin
                stat_retries <= stat_retries + 16'd1;
            end
        end
    end
`endif

endmodule
